mem_refill_arbiter: RTL and testbench
=====================================

// Module: mem_refill_arbiter
// PURPOSE
//  Shares one word-wide backing-memory port between the instruction-cache refill path and the
//  data-cache refill/write-back path of the cached RV32I core. Grants whole-line bursts
//  round-robin, generates beat addresses and steers read data back to the owner.
//  Sits between the two cache controllers and main memory, below the datapath.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  word width
//  LINE_WORDS   4  words per cache line, power of two, >=2; BEAT_W=$clog2(LINE_WORDS)
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst         in   1       synchronous, active-high reset
//  i_req       in   1       I-side line refill request; hold until i_done
//  i_addr      in   ADDR_W  I-side line address; low BEAT_W+2 bits ignored
//  i_gnt       out  1       1-cycle pulse: I-side burst started
//  i_rvalid    out  1       I-side beat data valid
//  i_beat      out  BEAT_W  beat index of i_rdata
//  i_rdata     out  DATA_W  refill word
//  i_done      out  1       1-cycle pulse with last I-side beat
//  d_req       in   1       D-side request; hold until d_done
//  d_we        in   1       1=line write-back, 0=line refill; sampled with d_req at grant
//  d_addr      in   ADDR_W  D-side line address; low BEAT_W+2 bits ignored
//  d_wdata     in   DATA_W  write-back word for index d_beat (combinational from d_beat)
//  d_gnt       out  1       1-cycle pulse: D-side burst started
//  d_rvalid    out  1       D-side refill beat valid (never during write-back)
//  d_beat      out  BEAT_W  current beat index of the D-side burst
//  d_rdata     out  DATA_W  refill word
//  d_done      out  1       1-cycle pulse with last D-side beat (read or write)
//  mem_req     out  1       memory access active this cycle
//  mem_we      out  1       write access
//  mem_addr    out  ADDR_W  {line_addr[ADDR_W-1:BEAT_W+2], beat, 2'b00}
//  mem_wdata   out  DATA_W  = d_wdata while D write-back owns the port, else 0
//  mem_ready   in   1       current word accepted (write) / mem_rdata valid (read)
//  mem_rdata   in   DATA_W  read word, valid only with mem_ready
//  busy        out  1       burst in progress
// BEHAVIOUR
//  - Reset: state IDLE, beat=0, last_owner=I; every output 0 (mem_addr 0).
//  - FSM IDLE -> BURST -> IDLE. In IDLE, if any req at edge: latch owner, line addr, d_we;
//    next cycle x_gnt=1, mem_req=1, busy=1, beat=0. At least one IDLE cycle between bursts.
//  - Arbitration: single requester wins; both -> the one NOT equal to last_owner (first tie
//    after reset goes to D). last_owner updates at grant.
//  - BURST: mem_req held high; beat advances only on mem_ready; mem_ready stalls indefinitely.
//    Read: on mem_ready, owner's x_rvalid=1, x_rdata=mem_rdata, x_beat=beat same cycle.
//  - Last beat (beat==LINE_WORDS-1 && mem_ready): x_done=1, beat wraps to 0, state -> IDLE,
//    mem_req deasserts next cycle.
//  - Non-owner x_rvalid/x_done/x_gnt stay 0; rdata outputs 0 when rvalid=0.
//  - req deasserted mid-burst is ignored: burst runs to completion. A req held after its
//    done is a new request, re-arbitrated in IDLE.
//  - rst mid-burst: immediate return to reset values next edge; no done pulse issued.
//  - mem_ready outside BURST is ignored.
// STRUCTURE
//  - mem_arb_pkg: typedef enum {ARB_IDLE, ARB_BURST} arb_state_t; typedef enum {OWN_I, OWN_D}
//    arb_owner_t; localparams BEAT_W, OFF_W=BEAT_W+2.
//  - One sub-module: arb_rr2 (combinational 2-way round-robin pick from reqs + last_owner).
//  - Beat counter, owner/addr registers and output steering live in this module.
// TESTING
//  1. rst high 2 cycles mid-activity -> all outputs 0, busy=0, next tie grants D.
//  2. i_req, i_addr=0x0000_1234, mem_ready always 1 -> i_gnt next cycle; mem_addr 0x1230,
//     0x1234, 0x1238, 0x123C on 4 consecutive cycles; i_done with 4th beat.
//  3. i_req & d_req same cycle after reset -> D first, then I after 1 idle cycle; repeat
//     tie -> I wins (alternation).
//  4. D write-back d_addr=0x2000, d_wdata=0xA0+d_beat, mem_ready on alternate cycles ->
//     mem_we=1, mem_wdata 0xA0..0xA3 each held until accepted, d_rvalid never high.
//  5. i_req dropped after grant -> burst completes all 4 beats, i_done pulses once.
//  6. rst asserted at beat 2 of D refill -> no d_done, mem_req=0 next cycle, beat=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the I/D refill arbiter.
package mem_arb_pkg;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned BEAT_W         = $clog2(LINE_WORDS_DEF);
    localparam int unsigned OFF_W          = BEAT_W + 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side that did not win last.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_owner,
    output logic       any_c,
    output arb_owner_t pick_c
);

    always_comb begin
        any_c  = i_req | d_req;
        pick_c = OWN_I;
        if (i_req && d_req) begin
            pick_c = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            pick_c = OWN_D;
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one word-wide memory port between I-cache refills and D-cache refills/write-backs,
// granting whole-line bursts round-robin and steering beat data back to the owner.
module mem_refill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    localparam int unsigned BEAT_BITS = $clog2(LINE_WORDS),
    localparam int unsigned OFF_BITS  = BEAT_BITS + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [BEAT_BITS-1:0] i_beat,
    output logic [DATA_W-1:0]    i_rdata,
    output logic                 i_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [BEAT_BITS-1:0] d_beat,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 d_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_ready,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy
);

    localparam int unsigned LINE_W = ADDR_W - OFF_BITS;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);

    arb_state_t           state;
    arb_owner_t           owner;
    arb_owner_t           last_owner;
    arb_owner_t           pick_c;
    logic                 any_c;
    logic                 we_q;
    logic [LINE_W-1:0]    line_q;
    logic [BEAT_BITS-1:0] beat;

    logic [LINE_W-1:0]    req_line_c;
    logic                 own_i_c;
    logic                 own_d_c;
    logic                 last_c;
    logic                 unused_offsets;

    assign unused_offsets = ^{i_addr[OFF_BITS-1:0], d_addr[OFF_BITS-1:0]};

    arb_rr2 u_rr (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_owner),
        .any_c      (any_c),
        .pick_c     (pick_c)
    );

    // Read data and beat handshakes are same-cycle with mem_ready, so they are steered combinationally.
    always_comb begin
        req_line_c = (pick_c == OWN_D) ? d_addr[ADDR_W-1:OFF_BITS] : i_addr[ADDR_W-1:OFF_BITS];
        own_i_c    = (state == ARB_BURST) && (owner == OWN_I);
        own_d_c    = (state == ARB_BURST) && (owner == OWN_D);
        last_c     = mem_ready && (beat == LAST_BEAT);

        i_rvalid   = own_i_c && mem_ready;
        i_rdata    = i_rvalid ? mem_rdata : '0;
        i_beat     = own_i_c ? beat : '0;
        i_done     = own_i_c && last_c;

        d_rvalid   = own_d_c && !we_q && mem_ready;
        d_rdata    = d_rvalid ? mem_rdata : '0;
        d_beat     = own_d_c ? beat : '0;
        d_done     = own_d_c && last_c;

        mem_wdata  = (own_d_c && we_q) ? d_wdata : '0;
    end

    // Burst FSM with beat counter, owner/line capture and registered port controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= OWN_I;
            last_owner <= OWN_I;
            we_q       <= 1'b0;
            line_q     <= '0;
            beat       <= '0;
            i_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
        end else begin
            i_gnt <= 1'b0;
            d_gnt <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (any_c) begin
                        state      <= ARB_BURST;
                        owner      <= pick_c;
                        last_owner <= pick_c;
                        we_q       <= (pick_c == OWN_D) && d_we;
                        line_q     <= req_line_c;
                        beat       <= '0;
                        i_gnt      <= (pick_c == OWN_I);
                        d_gnt      <= (pick_c == OWN_D);
                        mem_req    <= 1'b1;
                        mem_we     <= (pick_c == OWN_D) && d_we;
                        mem_addr   <= {req_line_c, BEAT_BITS'(0), 2'b00};
                        busy       <= 1'b1;
                    end
                end
                ARB_BURST: begin
                    if (mem_ready) begin
                        if (beat == LAST_BEAT) begin
                            state    <= ARB_IDLE;
                            beat     <= '0;
                            we_q     <= 1'b0;
                            mem_req  <= 1'b0;
                            mem_we   <= 1'b0;
                            mem_addr <= '0;
                            busy     <= 1'b0;
                        end else begin
                            beat     <= beat + BEAT_BITS'(1);
                            mem_addr <= {line_q, beat + BEAT_BITS'(1), 2'b00};
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed self-checking bench for mem_refill_arbiter (4-word lines, 32-bit address/data).
module tb_mem_refill_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BEAT_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [BEAT_W-1:0] i_beat;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [BEAT_W-1:0] d_beat;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Write-back source and memory read model: data is a fixed function of the beat/address.
    assign d_wdata   = 32'hA0 + 32'(d_beat);
    assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

    mem_refill_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_beat    (i_beat),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_beat    (d_beat),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done, mem_req, mem_we, busy} !== 9'b0) begin
            $display("FAIL reset_ctrl: got %b want 000000000",
                     {i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done, mem_req, mem_we, busy});
            errors++;
        end
        checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata, i_beat, d_beat} !== '0) begin
            $display("FAIL reset_data: addr=%h wdata=%h ird=%h drd=%h ib=%0d db=%0d want all 0",
                     mem_addr, mem_wdata, i_rdata, d_rdata, i_beat, d_beat);
            errors++;
        end
        // start an I burst that stalls, then reset in the middle of it
        i_req = 1'b1;
        i_addr = 32'h5000;
        mem_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, mem_req} !== 2'b11) begin
            $display("FAIL reset_pre_busy: got %b want 11", {busy, mem_req});
            errors++;
        end
        rst = 1'b1;
        i_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, mem_req, i_gnt, i_beat, mem_addr} !== '0) begin
            $display("FAIL reset_mid: busy=%b req=%b gnt=%b beat=%0d addr=%h want 0",
                     busy, mem_req, i_gnt, i_beat, mem_addr);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_tie_alternation;
        logic          is_d;
        logic [31:0]   base;
        logic [31:0]   exp_addr;
        i_req = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        i_addr = 32'h4000;
        d_addr = 32'h3000;
        mem_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            is_d = (k != 1);
            base = is_d ? 32'h3000 : 32'h4000;
            checks++;
            if ({i_gnt, d_gnt} !== {!is_d, is_d}) begin
                $display("FAIL tie_gnt%0d: i/d gnt=%b want %b", k, {i_gnt, d_gnt}, {!is_d, is_d});
                errors++;
            end
            for (int b = 0; b < 4; b++) begin
                exp_addr = base + 32'(4 * b);
                checks++;
                if (mem_addr !== exp_addr) begin
                    $display("FAIL tie_addr%0d_%0d: got %h want %h", k, b, mem_addr, exp_addr);
                    errors++;
                end
                checks++;
                if ({i_rvalid, d_rvalid, i_done, d_done} !==
                    {!is_d, is_d, (b == 3) && !is_d, (b == 3) && is_d}) begin
                    $display("FAIL tie_flags%0d_%0d: got %b want %b", k, b,
                             {i_rvalid, d_rvalid, i_done, d_done},
                             {!is_d, is_d, (b == 3) && !is_d, (b == 3) && is_d});
                    errors++;
                end
                checks++;
                if ((is_d ? d_rdata : i_rdata) !== (exp_addr ^ 32'hDEAD_0000) ||
                    (is_d ? i_rdata : d_rdata) !== 32'h0) begin
                    $display("FAIL tie_rdata%0d_%0d: i=%h d=%h want owner %h", k, b,
                             i_rdata, d_rdata, exp_addr ^ 32'hDEAD_0000);
                    errors++;
                end
                if (k == 2 && b == 3) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                end
                tick();
            end
            checks++;
            if ({busy, mem_req, i_gnt, d_gnt} !== 4'b0) begin
                $display("FAIL tie_idle%0d: got %b want 0000", k, {busy, mem_req, i_gnt, d_gnt});
                errors++;
            end
            tick();
        end
        checks++;
        if ({busy, i_gnt, d_gnt} !== 3'b0) begin
            $display("FAIL tie_quiet: got %b want 000", {busy, i_gnt, d_gnt});
            errors++;
        end
    endtask

    task automatic test_single_read;
        logic [31:0] exp_addr;
        i_req = 1'b1;
        i_addr = 32'h1234;
        mem_ready = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            exp_addr = 32'h1230 + 32'(4 * b);
            checks++;
            if ({i_gnt, mem_req, busy, mem_we} !== {b == 0, 1'b1, 1'b1, 1'b0}) begin
                $display("FAIL read_ctrl%0d: gnt/req/busy/we=%b want %b", b,
                         {i_gnt, mem_req, busy, mem_we}, {b == 0, 1'b1, 1'b1, 1'b0});
                errors++;
            end
            checks++;
            if (mem_addr !== exp_addr) begin
                $display("FAIL read_addr%0d: got %h want %h", b, mem_addr, exp_addr);
                errors++;
            end
            checks++;
            if ({i_rvalid, i_beat, i_done, d_rvalid} !== {1'b1, 2'(b), b == 3, 1'b0}) begin
                $display("FAIL read_beat%0d: got %b want %b", b,
                         {i_rvalid, i_beat, i_done, d_rvalid}, {1'b1, 2'(b), b == 3, 1'b0});
                errors++;
            end
            checks++;
            if (i_rdata !== (exp_addr ^ 32'hDEAD_0000)) begin
                $display("FAIL read_data%0d: got %h want %h", b, i_rdata, exp_addr ^ 32'hDEAD_0000);
                errors++;
            end
            if (b == 3) i_req = 1'b0;
            tick();
        end
        checks++;
        if ({mem_req, busy, i_rvalid, i_done, mem_addr} !== '0) begin
            $display("FAIL read_end: req=%b busy=%b rv=%b done=%b addr=%h want 0",
                     mem_req, busy, i_rvalid, i_done, mem_addr);
            errors++;
        end
    endtask

    task automatic test_writeback;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h2000;
        mem_ready = 1'b0;
        tick();
        checks++;
        if ({d_gnt, i_gnt, mem_we, mem_req} !== 4'b1011) begin
            $display("FAIL wb_gnt: d/i gnt, we, req=%b want 1011", {d_gnt, i_gnt, mem_we, mem_req});
            errors++;
        end
        d_req = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 2; r++) begin
                mem_ready = (r == 1);
                settle();
                checks++;
                if (mem_addr !== 32'h2000 + 32'(4 * b) || mem_wdata !== 32'hA0 + 32'(b)) begin
                    $display("FAIL wb_word%0d_%0d: addr=%h wdata=%h want %h %h", b, r,
                             mem_addr, mem_wdata, 32'h2000 + 32'(4 * b), 32'hA0 + 32'(b));
                    errors++;
                end
                checks++;
                if ({d_rvalid, i_rvalid, d_done, d_beat, mem_we} !==
                    {1'b0, 1'b0, (r == 1) && (b == 3), 2'(b), 1'b1}) begin
                    $display("FAIL wb_flags%0d_%0d: got %b want %b", b, r,
                             {d_rvalid, i_rvalid, d_done, d_beat, mem_we},
                             {1'b0, 1'b0, (r == 1) && (b == 3), 2'(b), 1'b1});
                    errors++;
                end
                tick();
            end
        end
        mem_ready = 1'b0;
        settle();
        checks++;
        if ({mem_req, mem_we, busy, mem_wdata} !== '0) begin
            $display("FAIL wb_end: req=%b we=%b busy=%b wdata=%h want 0",
                     mem_req, mem_we, busy, mem_wdata);
            errors++;
        end
    endtask

    task automatic test_req_drop;
        int n_rv;
        int n_done;
        n_rv = 0;
        n_done = 0;
        i_req = 1'b1;
        i_addr = 32'h6010;
        mem_ready = 1'b1;
        tick();
        checks++;
        if (i_gnt !== 1'b1 || mem_addr !== 32'h6010) begin
            $display("FAIL drop_gnt: gnt=%b addr=%h want 1 00006010", i_gnt, mem_addr);
            errors++;
        end
        i_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (i_rvalid === 1'b1) n_rv++;
            if (i_done === 1'b1) n_done++;
            tick();
        end
        checks++;
        if (n_rv !== 4 || n_done !== 1 || busy !== 1'b0) begin
            $display("FAIL drop_count: beats=%0d dones=%0d busy=%b want 4 1 0", n_rv, n_done, busy);
            errors++;
        end
    endtask

    task automatic test_rst_mid;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h7000;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (d_beat !== 2'd2 || d_done !== 1'b0 || mem_addr !== 32'h7008) begin
            $display("FAIL rstmid_pre: beat=%0d done=%b addr=%h want 2 0 00007008",
                     d_beat, d_done, mem_addr);
            errors++;
        end
        rst = 1'b1;
        d_req = 1'b0;
        settle();
        checks++;
        if (d_done !== 1'b0) begin
            $display("FAIL rstmid_nodone: got %b want 0", d_done);
            errors++;
        end
        tick();
        checks++;
        if ({mem_req, busy, d_beat, d_done, d_rvalid, d_gnt, mem_addr} !== '0) begin
            $display("FAIL rstmid_post: req=%b busy=%b beat=%0d done=%b rv=%b gnt=%b addr=%h want 0",
                     mem_req, busy, d_beat, d_done, d_rvalid, d_gnt, mem_addr);
            errors++;
        end
        rst = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        i_addr = 32'h1000;
        d_addr = 32'h8000;
        tick();
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01 || mem_addr !== 32'h8000) begin
            $display("FAIL rstmid_tie: i/d gnt=%b addr=%h want 01 00008000", {i_gnt, d_gnt}, mem_addr);
            errors++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        for (int c = 0; c < 5; c++) tick();
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0;
        i_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = '0;
        mem_ready = 1'b0;
        test_reset();
        test_tie_alternation();
        test_single_read();
        test_writeback();
        test_req_drop();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
